// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter for two requesters sharing a byte RAM,
// with a lock option that keeps ownership across consecutive accesses.
module ram_arbiter #(
    parameter int RAMSIZE = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic       lock0,
    input  logic       lock1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       rvalid0,
    output logic       rvalid1,
    output logic [7:0] rdata,
    output logic       err,
    output logic       owner
);
    localparam int AW = RAMSIZE > 1 ? $clog2(RAMSIZE) : 1;
    localparam logic [8:0] LIMIT = 9'(RAMSIZE);
    typedef enum logic [1:0] {IDLE, ACCESS, LOCKED} state_t;
    state_t state, state_nx;
    logic [7:0] ram [RAMSIZE];
    logic          a_we, a_lock, take, win, in_range;
    logic [7:0]    a_addr, a_wdata;
    logic [AW-1:0] idx;
    // full 8-bit compare: out-of-range addresses never alias onto low RAM
    assign in_range = {1'b0, a_addr} < LIMIT;
    assign idx      = a_addr[AW-1:0];
    always_comb begin
        win      = state == LOCKED ? owner : (req0 && req1 ? ~owner : req1);
        take     = state == LOCKED ? (owner ? req1 : req0) : (state == IDLE && (req0 || req1));
        state_nx = take ? ACCESS : state == ACCESS ? (a_lock ? LOCKED : IDLE) : IDLE;
    end
    always_ff @(posedge clk) begin
        gnt0    <= 1'b0;
        gnt1    <= 1'b0;
        rvalid0 <= 1'b0;
        rvalid1 <= 1'b0;
        err     <= 1'b0;
        if (reset) begin
            state <= IDLE;
            owner <= 1'b1;
            rdata <= '0;
        end else begin
            state <= state_nx;
            if (take) begin
                owner   <= win;
                a_we    <= win ? we1 : we0;
                a_lock  <= win ? lock1 : lock0;
                a_addr  <= win ? addr1 : addr0;
                a_wdata <= win ? wdata1 : wdata0;
                gnt0    <= ~win;
                gnt1    <= win;
            end
            if (state == ACCESS) begin
                err <= ~in_range;
                if (!a_we) begin
                    rdata   <= in_range ? ram[idx] : '0;
                    rvalid0 <= ~owner;
                    rvalid1 <= owner;
                end
            end
        end
    end
    // RAM has no reset so loader contents survive it; reset still blocks a pending write
    always_ff @(posedge clk)
        if (!reset && state == ACCESS && a_we && in_range) ram[idx] <= a_wdata;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: transaction-level model of the arbiter checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ram_arbiter;
    localparam int RAMSIZE = 64;
    logic clk = 0, reset = 1;
    logic [1:0] req = 0, we = 0, lock = 0;
    logic [7:0] addr [2], wdata [2];
    logic gnt0, gnt1, rvalid0, rvalid1, err, owner;
    logic [7:0] rdata;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.RAMSIZE(RAMSIZE)) dut (
        .clk(clk), .reset(reset),
        .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
        .lock0(lock[0]), .lock1(lock[1]),
        .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .err(err), .owner(owner)
    );

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: a pending transaction, who holds the lock, who owned last, and the RAM image
    logic [7:0] mem [RAMSIZE];
    bit         chk_en = 0, pend = 0, p_we, p_lock, e_err;
    int         holder = -1, m_owner = 1, p_port, p_addr;
    logic [7:0] p_wd, e_rdata = 0;
    bit [1:0]   e_gnt, e_rv;
    int         glog[$];
    logic [7:0] rlog0[$];

    always @(posedge clk) begin
        int w;
        e_gnt = 0;
        e_rv  = 0;
        e_err = 0;
        if (reset) begin
            chk_en = 1; pend = 0; holder = -1; m_owner = 1; e_rdata = 0;
        end else if (pend) begin
            pend = 0;
            if (p_addr < RAMSIZE) begin
                if (p_we) mem[p_addr] = p_wd;
                else begin e_rdata = mem[p_addr]; e_rv[p_port] = 1; end
            end else begin
                e_err = 1;
                if (!p_we) begin e_rdata = 0; e_rv[p_port] = 1; end
            end
            holder = p_lock ? p_port : -1;
        end else begin
            if (holder >= 0) w = req[holder] ? holder : -1;
            else if (req == 2'b11) w = 1 - m_owner;
            else w = req[0] ? 0 : req[1] ? 1 : -1;
            holder = -1;
            if (w >= 0) begin
                pend = 1; p_port = w; p_we = we[w]; p_addr = int'(addr[w]);
                p_lock = lock[w]; p_wd = wdata[w]; m_owner = w; e_gnt[w] = 1;
            end
        end
        #1;
        if (chk_en) begin
            check("gnt0", gnt0, e_gnt[0]);
            check("gnt1", gnt1, e_gnt[1]);
            check("rvalid0", rvalid0, e_rv[0]);
            check("rvalid1", rvalid1, e_rv[1]);
            check("err", err, e_err);
            check("owner", owner, m_owner[0]);
            check("rdata", rdata, e_rdata);
        end
        if (gnt0) glog.push_back(0);
        if (gnt1) glog.push_back(1);
        if (rvalid0) rlog0.push_back(rdata);
    end

    // raise a request, hold it until its grant, drop it inside the grant cycle
    task automatic access(input int p, input bit w, input logic [7:0] a, input logic [7:0] d,
                          input bit lk, output int waited);
        req[p] = 1; we[p] = w; addr[p] = a; wdata[p] = d; lock[p] = lk;
        waited = 0;
        do begin @(posedge clk); #1; waited++; end
        while (!(p == 1 ? gnt1 : gnt0) && waited < 40);
        if (!(p == 1 ? gnt1 : gnt0)) check("grant_timeout", 0, 1);
        req[p] = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        int w;
        logic [7:0] fill [RAMSIZE];
        addr[0] = 0; addr[1] = 0; wdata[0] = 0; wdata[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", {gnt1, gnt0}, 0);
        check("rst_rvalid", {rvalid1, rvalid0}, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        check("rst_owner", owner, 1);
        reset = 0;
        access(1, 1, 8'd5, 8'h2A, 0, w);
        check("gnt1_latency", w, 1);
        access(0, 0, 8'd5, 8'h00, 0, w);
        check("gnt0_latency", w, 2);
        step();
        check("rd5_rvalid0", rvalid0, 1);
        check("rd5_data", rdata, 8'h2A);
        for (int i = 0; i < RAMSIZE; i++) begin
            fill[i] = 8'($urandom);
            access(1, 1, 8'(i), fill[i], 0, w);
        end
        repeat (2) step();
        glog.delete();
        fork
            begin int t; for (int i = 0; i < 4; i++) access(0, 0, 8'($urandom_range(0, 63)), 0, 0, t); end
            begin int t; for (int i = 0; i < 4; i++) access(1, 0, 8'($urandom_range(0, 63)), 0, 0, t); end
        join
        repeat (2) step();
        check("rr_count", glog.size(), 8);
        for (int i = 0; i < 8; i++) check("rr_order", i < glog.size() ? glog[i] : 9, i % 2);
        glog.delete();
        rlog0.delete();
        fork
            begin int t; for (int i = 0; i < 4; i++) access(0, 0, 8'(i), 0, i < 3, t); end
            begin int t; access(1, 0, 8'd10, 0, 0, t); end
        join
        repeat (3) step();
        check("lock_count", glog.size(), 5);
        for (int i = 0; i < 5; i++) check("lock_order", i < glog.size() ? glog[i] : 9, i == 4);
        check("lock_reads", rlog0.size(), 4);
        for (int i = 0; i < 4; i++) check("lock_data", i < rlog0.size() ? rlog0[i] : 9'h1FF, fill[i]);
        access(1, 1, 8'd64, 8'h55, 0, w);
        step();
        check("wr64_err", err, 1);
        check("wr64_rvalid", rvalid1, 0);
        access(1, 0, 8'd0, 0, 0, w);
        step();
        check("rd0_rvalid", rvalid1, 1);
        check("rd0_data", rdata, fill[0]);
        access(1, 0, 8'd64, 0, 0, w);
        step();
        check("rd64_rvalid", rvalid1, 1);
        check("rd64_err", err, 1);
        check("rd64_data", rdata, 0);
        access(1, 1, 8'd9, 8'h11, 0, w);
        step();
        access(0, 1, 8'd9, 8'hFF, 0, w);
        reset = 1;
        step();
        check("rstacc_gnt", {gnt1, gnt0}, 0);
        check("rstacc_rvalid", {rvalid1, rvalid0}, 0);
        check("rstacc_err", err, 0);
        check("rstacc_rdata", rdata, 0);
        check("rstacc_owner", owner, 1);
        reset = 0;
        access(1, 0, 8'd9, 0, 0, w);
        step();
        check("rd9_rvalid", rvalid1, 1);
        check("rd9_data", rdata, 8'h11);
        fork
            begin
                int t;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) step();
                    access(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 70)), 8'($urandom),
                           $urandom_range(0, 3) == 0, t);
                end
            end
            begin
                int t;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) step();
                    access(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 70)), 8'($urandom),
                           $urandom_range(0, 3) == 0, t);
                end
            end
        join
        repeat (4) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
